// File: rtl/imem_loader_if.sv
// Byte-stream and instruction-memory write bus for the program loader.
// The slave modport is the loader's view. The master modport is the view of
// the side that drives the stream and observes the writes.
interface imem_loader_if;
   logic        start_in;
   logic [7:0]  byte_in;
   logic        byte_valid_in;
   logic        byte_ready_out;
   logic [31:0] address_out;
   logic [31:0] data_out;
   logic        write_out;
   logic        cpu_reset_out;
   logic        done_out;
   logic        error_out;

   modport slave (
      input  start_in, byte_in, byte_valid_in,
      output byte_ready_out, address_out, data_out, write_out,
             cpu_reset_out, done_out, error_out
   );

   modport master (
      output start_in, byte_in, byte_valid_in,
      input  byte_ready_out, address_out, data_out, write_out,
             cpu_reset_out, done_out, error_out
   );
endinterface

// File: rtl/imem_loader.sv
// Program loader: accepts a framed byte stream (16-bit word count, big-endian
// words, XOR checksum) and writes each word to instruction memory. It holds the
// CPU in reset until a frame completes with a matching checksum.
module imem_loader #(
   parameter logic [31:0] BASE_ADDR = 32'h0,
   parameter int unsigned MAX_WORDS = 256
) (
   input logic          clk,
   input logic          reset_in,
   imem_loader_if.slave bus
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LEN_HI,
      ST_LEN_LO,
      ST_DATA,
      ST_WRITE,
      ST_CSUM,
      ST_DONE,
      ST_ERROR
   } state_t;

   state_t      state;
   logic [15:0] word_len;
   logic [15:0] word_cnt;
   logic [1:0]  byte_idx;
   logic [7:0]  csum;
   logic        accept;
   logic [15:0] len_full;

   // Handshake qualifier, and the word count as it looks once LEN_LO arrives.
   always_comb begin
      accept   = bus.byte_valid_in & bus.byte_ready_out;
      len_full = {word_len[15:8], bus.byte_in};
   end

   // Loader FSM. byte_ready_out is registered, so it is set on the edge that
   // enters a byte-accepting state and cleared on the edge that leaves one.
   always_ff @(posedge clk) begin
      if (!reset_in) begin
         state              <= ST_IDLE;
         word_len           <= '0;
         word_cnt           <= '0;
         byte_idx           <= '0;
         csum               <= '0;
         bus.byte_ready_out <= 1'b0;
         bus.write_out      <= 1'b0;
         bus.address_out    <= BASE_ADDR;
         bus.data_out       <= '0;
         bus.cpu_reset_out  <= 1'b1;
         bus.done_out       <= 1'b0;
         bus.error_out      <= 1'b0;
      end else begin
         bus.write_out <= 1'b0;
         unique case (state)
            ST_IDLE, ST_DONE, ST_ERROR: begin
               if (bus.start_in) begin
                  csum               <= '0;
                  word_cnt           <= '0;
                  byte_idx           <= '0;
                  bus.done_out       <= 1'b0;
                  bus.error_out      <= 1'b0;
                  bus.cpu_reset_out  <= 1'b1;
                  bus.address_out    <= BASE_ADDR;
                  bus.byte_ready_out <= 1'b1;
                  state              <= ST_LEN_HI;
               end
            end
            ST_LEN_HI: begin
               if (accept) begin
                  word_len[15:8] <= bus.byte_in;
                  csum           <= csum ^ bus.byte_in;
                  state          <= ST_LEN_LO;
               end
            end
            ST_LEN_LO: begin
               if (accept) begin
                  word_len[7:0] <= bus.byte_in;
                  csum          <= csum ^ bus.byte_in;
                  if (32'(len_full) > MAX_WORDS) begin
                     bus.byte_ready_out <= 1'b0;
                     bus.error_out      <= 1'b1;
                     state              <= ST_ERROR;
                  end else if (len_full == 16'd0) begin
                     state <= ST_CSUM;
                  end else begin
                     state <= ST_DATA;
                  end
               end
            end
            ST_DATA: begin
               if (accept) begin
                  bus.data_out <= {bus.data_out[23:0], bus.byte_in};
                  csum         <= csum ^ bus.byte_in;
                  byte_idx     <= byte_idx + 2'd1;
                  if (byte_idx == 2'd3) begin
                     bus.byte_ready_out <= 1'b0;
                     bus.write_out      <= 1'b1;
                     state              <= ST_WRITE;
                  end
               end
            end
            ST_WRITE: begin
               bus.address_out    <= bus.address_out + 32'd4;
               word_cnt           <= word_cnt + 16'd1;
               bus.byte_ready_out <= 1'b1;
               if (word_cnt + 16'd1 == word_len) begin
                  state <= ST_CSUM;
               end else begin
                  state <= ST_DATA;
               end
            end
            ST_CSUM: begin
               if (accept) begin
                  bus.byte_ready_out <= 1'b0;
                  if (bus.byte_in == csum) begin
                     bus.done_out      <= 1'b1;
                     bus.cpu_reset_out <= 1'b0;
                     state             <= ST_DONE;
                  end else begin
                     bus.error_out <= 1'b1;
                     state         <= ST_ERROR;
                  end
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: good and bad frames, length overflow, empty
// frame, stream gaps and reset in the middle of a load.
module tb_imem_loader;

   logic clk = 1'b0;
   logic reset_in;
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   // Free-running cycle count used for throughput measurement.
   always @(posedge clk) cyc <= cyc + 1;

   imem_loader_if bus ();

   imem_loader #(
      .BASE_ADDR (32'h0),
      .MAX_WORDS (256)
   ) dut (
      .clk      (clk),
      .reset_in (reset_in),
      .bus      (bus)
   );

   logic [31:0] wr_addr[$];
   logic [31:0] wr_data[$];
   logic [7:0]  frame[$];

   // Records every write strobe seen between clock edges.
   always @(negedge clk) begin
      if (bus.write_out === 1'b1) begin
         wr_addr.push_back(bus.address_out);
         wr_data.push_back(bus.data_out);
      end
   end

   task automatic send_byte(input logic [7:0] b, input int unsigned bound, output bit ok);
      ok = 1'b0;
      bus.byte_in       = b;
      bus.byte_valid_in = 1'b1;
      for (int unsigned i = 0; i < bound; i++) begin
         if (bus.byte_ready_out === 1'b1) begin
            @(posedge clk);
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      if (ok) @(negedge clk);
      bus.byte_valid_in = 1'b0;
   endtask

   task automatic send_frame(input bit gaps, output int cycles);
      bit ok;
      int c0;
      c0 = cyc;
      for (int i = 0; i < frame.size(); i++) begin
         if (gaps) repeat ((i * 7 + 3) % 4) @(negedge clk);
         send_byte(frame[i], 40, ok);
         checks++;
         if (!ok) begin
            failures++;
            $display("FAIL byte_accept idx=%0d byte=%02h accepted=0 required=1", i, frame[i]);
         end
      end
      cycles = cyc - c0;
   endtask

   task automatic pulse_start();
      bus.start_in = 1'b1;
      @(negedge clk);
      bus.start_in = 1'b0;
   endtask

   // Two-word frame; XOR of all frame bytes is 0x29.
   task automatic load_frame(input logic [7:0] csum_byte);
      frame = '{8'h00, 8'h02, 8'h20, 8'h02, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h0C, csum_byte};
   endtask

   task automatic test_reset();
      reset_in     = 1'b0;
      bus.start_in = 1'b1;
      repeat (2) @(negedge clk);
      checks++; if (bus.byte_ready_out !== 1'b0) begin failures++; $display("FAIL rst_ready got=%b exp=0", bus.byte_ready_out); end
      checks++; if (bus.write_out !== 1'b0) begin failures++; $display("FAIL rst_write got=%b exp=0", bus.write_out); end
      checks++; if (bus.address_out !== 32'h0) begin failures++; $display("FAIL rst_addr got=%h exp=00000000", bus.address_out); end
      checks++; if (bus.data_out !== 32'h0) begin failures++; $display("FAIL rst_data got=%h exp=00000000", bus.data_out); end
      checks++; if (bus.cpu_reset_out !== 1'b1) begin failures++; $display("FAIL rst_cpu_reset got=%b exp=1", bus.cpu_reset_out); end
      checks++; if (bus.done_out !== 1'b0) begin failures++; $display("FAIL rst_done got=%b exp=0", bus.done_out); end
      checks++; if (bus.error_out !== 1'b0) begin failures++; $display("FAIL rst_error got=%b exp=0", bus.error_out); end
      bus.start_in = 1'b0;
      reset_in     = 1'b1;
      @(negedge clk);
      checks++; if (bus.byte_ready_out !== 1'b0) begin failures++; $display("FAIL rst_start_priority ready got=%b exp=0", bus.byte_ready_out); end
   endtask

   task automatic test_good_frame();
      int cycles;
      wr_addr.delete(); wr_data.delete();
      pulse_start();
      checks++; if (bus.byte_ready_out !== 1'b1) begin failures++; $display("FAIL good_ready_after_start got=%b exp=1", bus.byte_ready_out); end
      checks++; if (bus.cpu_reset_out !== 1'b1) begin failures++; $display("FAIL good_cpu_reset_loading got=%b exp=1", bus.cpu_reset_out); end
      load_frame(8'h29);
      send_frame(1'b0, cycles);
      @(negedge clk);
      checks++; if (cycles != 13) begin failures++; $display("FAIL good_cycles got=%0d exp=13", cycles); end
      checks++; if (wr_addr.size() != 2) begin failures++; $display("FAIL good_write_count got=%0d exp=2", wr_addr.size()); end
      else begin
         checks++; if (wr_addr[0] !== 32'h0) begin failures++; $display("FAIL good_addr0 got=%h exp=00000000", wr_addr[0]); end
         checks++; if (wr_data[0] !== 32'h20020005) begin failures++; $display("FAIL good_data0 got=%h exp=20020005", wr_data[0]); end
         checks++; if (wr_addr[1] !== 32'h4) begin failures++; $display("FAIL good_addr1 got=%h exp=00000004", wr_addr[1]); end
         checks++; if (wr_data[1] !== 32'h0000000C) begin failures++; $display("FAIL good_data1 got=%h exp=0000000c", wr_data[1]); end
      end
      checks++; if (bus.done_out !== 1'b1) begin failures++; $display("FAIL good_done got=%b exp=1", bus.done_out); end
      checks++; if (bus.error_out !== 1'b0) begin failures++; $display("FAIL good_error got=%b exp=0", bus.error_out); end
      checks++; if (bus.cpu_reset_out !== 1'b0) begin failures++; $display("FAIL good_cpu_reset got=%b exp=0", bus.cpu_reset_out); end
   endtask

   task automatic test_bad_csum();
      int cycles;
      wr_addr.delete(); wr_data.delete();
      pulse_start();
      checks++; if (bus.cpu_reset_out !== 1'b1) begin failures++; $display("FAIL bad_restart_cpu_reset got=%b exp=1", bus.cpu_reset_out); end
      checks++; if (bus.done_out !== 1'b0) begin failures++; $display("FAIL bad_restart_done got=%b exp=0", bus.done_out); end
      load_frame(8'h2A);
      send_frame(1'b0, cycles);
      @(negedge clk);
      checks++; if (wr_addr.size() != 2) begin failures++; $display("FAIL bad_write_count got=%0d exp=2", wr_addr.size()); end
      else begin
         checks++; if (wr_data[1] !== 32'h0000000C || wr_addr[1] !== 32'h4) begin failures++; $display("FAIL bad_write1 got=%h@%h exp=0000000c@00000004", wr_data[1], wr_addr[1]); end
      end
      checks++; if (bus.error_out !== 1'b1) begin failures++; $display("FAIL bad_error got=%b exp=1", bus.error_out); end
      checks++; if (bus.done_out !== 1'b0) begin failures++; $display("FAIL bad_done got=%b exp=0", bus.done_out); end
      checks++; if (bus.cpu_reset_out !== 1'b1) begin failures++; $display("FAIL bad_cpu_reset got=%b exp=1", bus.cpu_reset_out); end
   endtask

   task automatic test_overflow();
      int cycles;
      bit ok;
      wr_addr.delete(); wr_data.delete();
      pulse_start();
      checks++; if (bus.error_out !== 1'b0) begin failures++; $display("FAIL ovf_error_cleared got=%b exp=0", bus.error_out); end
      frame = '{8'h01, 8'h01};
      send_frame(1'b0, cycles);
      checks++; if (bus.error_out !== 1'b1) begin failures++; $display("FAIL ovf_error got=%b exp=1", bus.error_out); end
      checks++; if (bus.byte_ready_out !== 1'b0) begin failures++; $display("FAIL ovf_ready got=%b exp=0", bus.byte_ready_out); end
      send_byte(8'h00, 8, ok);
      checks++; if (ok) begin failures++; $display("FAIL ovf_later_byte accepted=1 required=0"); end
      checks++; if (wr_addr.size() != 0) begin failures++; $display("FAIL ovf_write_count got=%0d exp=0", wr_addr.size()); end
      checks++; if (bus.cpu_reset_out !== 1'b1) begin failures++; $display("FAIL ovf_cpu_reset got=%b exp=1", bus.cpu_reset_out); end
   endtask

   task automatic test_zero_len();
      int cycles;
      wr_addr.delete(); wr_data.delete();
      pulse_start();
      frame = '{8'h00, 8'h00, 8'h00};
      send_frame(1'b0, cycles);
      @(negedge clk);
      checks++; if (bus.done_out !== 1'b1) begin failures++; $display("FAIL zero_done got=%b exp=1", bus.done_out); end
      checks++; if (bus.error_out !== 1'b0) begin failures++; $display("FAIL zero_error got=%b exp=0", bus.error_out); end
      checks++; if (wr_addr.size() != 0) begin failures++; $display("FAIL zero_write_count got=%0d exp=0", wr_addr.size()); end
      checks++; if (bus.cpu_reset_out !== 1'b0) begin failures++; $display("FAIL zero_cpu_reset got=%b exp=0", bus.cpu_reset_out); end
   endtask

   task automatic test_gaps();
      int cycles;
      wr_addr.delete(); wr_data.delete();
      pulse_start();
      load_frame(8'h29);
      send_frame(1'b1, cycles);
      repeat (3) @(negedge clk);
      checks++; if (wr_addr.size() != 2) begin failures++; $display("FAIL gaps_write_count got=%0d exp=2", wr_addr.size()); end
      else begin
         checks++; if (wr_addr[0] !== 32'h0 || wr_data[0] !== 32'h20020005) begin failures++; $display("FAIL gaps_write0 got=%h@%h exp=20020005@00000000", wr_data[0], wr_addr[0]); end
         checks++; if (wr_addr[1] !== 32'h4 || wr_data[1] !== 32'h0000000C) begin failures++; $display("FAIL gaps_write1 got=%h@%h exp=0000000c@00000004", wr_data[1], wr_addr[1]); end
      end
      checks++; if (bus.done_out !== 1'b1) begin failures++; $display("FAIL gaps_done got=%b exp=1", bus.done_out); end
   endtask

   task automatic test_reset_mid_load();
      int cycles;
      wr_addr.delete(); wr_data.delete();
      pulse_start();
      frame = '{8'h00, 8'h02, 8'h20, 8'h02, 8'h00, 8'h05, 8'h00, 8'h00};
      send_frame(1'b0, cycles);
      checks++; if (wr_addr.size() != 1) begin failures++; $display("FAIL mid_pre_write_count got=%0d exp=1", wr_addr.size()); end
      reset_in          = 1'b0;
      bus.byte_in       = 8'h00;
      bus.byte_valid_in = 1'b1;
      @(negedge clk);
      bus.byte_valid_in = 1'b0;
      checks++; if (bus.write_out !== 1'b0) begin failures++; $display("FAIL mid_write got=%b exp=0", bus.write_out); end
      checks++; if (bus.cpu_reset_out !== 1'b1) begin failures++; $display("FAIL mid_cpu_reset got=%b exp=1", bus.cpu_reset_out); end
      checks++; if (bus.byte_ready_out !== 1'b0) begin failures++; $display("FAIL mid_ready got=%b exp=0", bus.byte_ready_out); end
      checks++; if (bus.address_out !== 32'h0) begin failures++; $display("FAIL mid_addr got=%h exp=00000000", bus.address_out); end
      reset_in = 1'b1;
      @(negedge clk);
      wr_addr.delete(); wr_data.delete();
      pulse_start();
      load_frame(8'h29);
      send_frame(1'b0, cycles);
      @(negedge clk);
      checks++; if (wr_addr.size() != 2) begin failures++; $display("FAIL mid_reload_write_count got=%0d exp=2", wr_addr.size()); end
      else begin
         checks++; if (wr_addr[0] !== 32'h0 || wr_data[0] !== 32'h20020005) begin failures++; $display("FAIL mid_reload_write0 got=%h@%h exp=20020005@00000000", wr_data[0], wr_addr[0]); end
         checks++; if (wr_addr[1] !== 32'h4 || wr_data[1] !== 32'h0000000C) begin failures++; $display("FAIL mid_reload_write1 got=%h@%h exp=0000000c@00000004", wr_data[1], wr_addr[1]); end
      end
      checks++; if (bus.done_out !== 1'b1) begin failures++; $display("FAIL mid_reload_done got=%b exp=1", bus.done_out); end
   endtask

   initial begin
      reset_in          = 1'b0;
      bus.start_in      = 1'b0;
      bus.byte_in       = 8'h00;
      bus.byte_valid_in = 1'b0;
      @(negedge clk);
      test_reset();
      test_good_frame();
      test_bad_csum();
      test_overflow();
      test_zero_len();
      test_gaps();
      test_reset_mid_load();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
